// File: rtl/clock_reset_pkg.sv
// Shared types for the clock/reset sequencer.
// State encoding and counter sizing helper.
package clock_reset_pkg;

  typedef enum logic [1:0] {
    HOLD,
    SETTLE,
    STAGE1,
    RUN
  } state_e;

  // Counter must hold the larger of the two dwell lengths without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
// Async active-high clear forces every stage to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw level in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser flops.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Staged reset release driven by MMCM lock status.
// Hub reset drops first, cog reset STAGE_GAP cycles later.
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int LOSS_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              locked,
  input  logic              soft_req,
  output logic              res_hub,
  output logic              res_cog,
  output logic              ready,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int CW = cnt_width(LOCK_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  logic locked_s;
  logic soft_s;
  logic soft_pulse;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              soft_prev_q;
  logic              res_hub_q, res_hub_d;
  logic              res_cog_q, res_cog_d;
  logic              ready_q, ready_d;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_locked (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (locked),
    .q      (locked_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_soft (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (soft_req),
    .q      (soft_s)
  );

  assign soft_pulse = soft_s & ~soft_prev_q;

  // Next state, dwell counter and loss counter; lock loss outranks soft restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      HOLD: begin
        if (locked_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (soft_pulse) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = STAGE1;
          cnt_d   = '0;
        end
      end
      STAGE1: begin
        cnt_d = cnt_q + 1'b1;
        if (!locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (soft_pulse) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (soft_pulse) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register glitch-free.
  always_comb begin
    res_hub_d = (state_d == HOLD) || (state_d == SETTLE);
    res_cog_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      loss_q      <= '0;
      soft_prev_q <= 1'b0;
      res_hub_q   <= 1'b1;
      res_cog_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      soft_prev_q <= soft_s;
      res_hub_q   <= res_hub_d;
      res_cog_q   <= res_cog_d;
      ready_q     <= ready_d;
    end
  end

  assign res_hub    = res_hub_q;
  assign res_cog    = res_cog_q;
  assign ready      = ready_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer.
// SYNC_STAGES=2, LOCK_CYCLES=8, STAGE_GAP=4, LOSS_W=8.
module tb_clock_reset_sequencer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       res_hub;
  logic       res_cog;
  logic       ready;
  logic [7:0] loss_count;

  int vectors = 0;
  int errs = 0;

  clock_reset_sequencer #(
    .SYNC_STAGES (2),
    .LOCK_CYCLES (8),
    .STAGE_GAP   (4),
    .LOSS_W      (8)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .locked     (locked),
    .soft_req   (soft_req),
    .res_hub    (res_hub),
    .res_cog    (res_cog),
    .ready      (ready),
    .loss_count (loss_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset values
    #1 rst = 1'b1;
    #3;
    chk("rst_hub", 32'(res_hub), 32'd1);
    chk("rst_cog", 32'(res_cog), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_loss", 32'(loss_count), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // first lock: hub drops after 11 edges, cog 4 later
    locked = 1'b1;
    tick(10);
    chk("lock_hub_e10", 32'(res_hub), 32'd1);
    tick(1);
    chk("lock_hub_e11", 32'(res_hub), 32'd0);
    chk("lock_cog_e11", 32'(res_cog), 32'd1);
    tick(3);
    chk("lock_cog_e14", 32'(res_cog), 32'd1);
    chk("lock_rdy_e14", 32'(ready), 32'd0);
    tick(1);
    chk("lock_cog_e15", 32'(res_cog), 32'd0);
    chk("lock_rdy_e15", 32'(ready), 32'd1);
    chk("lock_loss", 32'(loss_count), 32'd0);

    // lock loss in RUN: resets back after 3 edges
    locked = 1'b0;
    tick(2);
    chk("loss_hub_e2", 32'(res_hub), 32'd0);
    chk("loss_rdy_e2", 32'(ready), 32'd1);
    tick(1);
    chk("loss_hub_e3", 32'(res_hub), 32'd1);
    chk("loss_cog_e3", 32'(res_cog), 32'd1);
    chk("loss_rdy_e3", 32'(ready), 32'd0);
    chk("loss_cnt", 32'(loss_count), 32'd1);
    tick(4);

    // short lock pulse during SETTLE: no release, no loss
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("pulse_hub", 32'(res_hub), 32'd1);
    end
    chk("pulse_loss", 32'(loss_count), 32'd1);

    // relock: full sequence again
    locked = 1'b1;
    tick(10);
    chk("relock_hub_e10", 32'(res_hub), 32'd1);
    tick(1);
    chk("relock_hub_e11", 32'(res_hub), 32'd0);
    tick(3);
    chk("relock_rdy_e14", 32'(ready), 32'd0);
    tick(1);
    chk("relock_rdy_e15", 32'(ready), 32'd1);
    chk("relock_cog_e15", 32'(res_cog), 32'd0);

    // soft request held 10 cycles: one restart only
    soft_req = 1'b1;
    tick(2);
    chk("soft_rdy_e2", 32'(ready), 32'd1);
    tick(1);
    chk("soft_hub_e3", 32'(res_hub), 32'd1);
    chk("soft_cog_e3", 32'(res_cog), 32'd1);
    chk("soft_rdy_e3", 32'(ready), 32'd0);
    tick(7);
    chk("soft_hub_e10", 32'(res_hub), 32'd1);
    soft_req = 1'b0;
    tick(1);
    chk("soft_hub_e11", 32'(res_hub), 32'd0);
    chk("soft_cog_e11", 32'(res_cog), 32'd1);
    tick(3);
    chk("soft_cog_e14", 32'(res_cog), 32'd1);
    tick(1);
    chk("soft_cog_e15", 32'(res_cog), 32'd0);
    chk("soft_rdy_e15", 32'(ready), 32'd1);
    chk("soft_loss", 32'(loss_count), 32'd1);
    tick(10);
    chk("soft_once_rdy", 32'(ready), 32'd1);

    // simultaneous loss and soft edge: loss wins
    locked = 1'b0;
    soft_req = 1'b1;
    tick(3);
    chk("sim_hub", 32'(res_hub), 32'd1);
    chk("sim_rdy", 32'(ready), 32'd0);
    chk("sim_loss", 32'(loss_count), 32'd2);
    soft_req = 1'b0;
    tick(4);

    // forced losses from STAGE1 up to saturation
    for (int i = 0; i < 10; i++) begin
      locked = 1'b1;
      tick(12);
      locked = 1'b0;
      tick(4);
    end
    chk("sat_loss_12", 32'(loss_count), 32'd12);
    for (int i = 0; i < 243; i++) begin
      locked = 1'b1;
      tick(12);
      locked = 1'b0;
      tick(4);
    end
    chk("sat_loss_255", 32'(loss_count), 32'd255);
    for (int i = 0; i < 47; i++) begin
      locked = 1'b1;
      tick(12);
      locked = 1'b0;
      tick(4);
    end
    chk("sat_loss_hold", 32'(loss_count), 32'd255);

    // async reset mid-STAGE1
    locked = 1'b1;
    tick(12);
    chk("arst_pre_hub", 32'(res_hub), 32'd0);
    chk("arst_pre_cog", 32'(res_cog), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hub", 32'(res_hub), 32'd1);
    chk("arst_cog", 32'(res_cog), 32'd1);
    chk("arst_rdy", 32'(ready), 32'd0);
    chk("arst_loss", 32'(loss_count), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
